// File: rtl/alu_arb_if.sv
// Signal bundle between two requesters, the arbiter and the shared combinational ALU.
// The slave side is the arbiter; the master side is everything around it.
interface alu_arb_if;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [2:0]  req_op_0, req_op_1;
  logic [17:0] req_s1_0, req_s2_0;
  logic [17:0] req_s1_1, req_s2_1;
  logic        flags_clr_0, flags_clr_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic [17:0] rsp_res_0, rsp_res_1;
  logic [3:0]  rsp_flags_0, rsp_flags_1;
  logic [2:0]  alu_op;
  logic [17:0] alu_s1, alu_s2;
  logic [3:0]  alu_flags;
  logic [17:0] alu_res;
  logic [3:0]  alu_new_flags;

  modport slave (
    input  req_valid_0, req_valid_1, req_op_0, req_op_1,
    input  req_s1_0, req_s2_0, req_s1_1, req_s2_1,
    input  flags_clr_0, flags_clr_1,
    input  alu_res, alu_new_flags,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_res_0, rsp_res_1, rsp_flags_0, rsp_flags_1,
    output alu_op, alu_s1, alu_s2, alu_flags
  );

  modport master (
    output req_valid_0, req_valid_1, req_op_0, req_op_1,
    output req_s1_0, req_s2_0, req_s1_1, req_s2_1,
    output flags_clr_0, flags_clr_1,
    output alu_res, alu_new_flags,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_res_0, rsp_res_1, rsp_flags_0, rsp_flags_1,
    input  alu_op, alu_s1, alu_s2, alu_flags
  );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Accept -> issue register drives the ALU -> response register; per-requester flags.
module alu_arb #(
  parameter int unsigned RR_INIT = 0
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_arb_if.slave bus
);
  localparam logic PTR_RST = (RR_INIT != 0);

  logic [1:0]  valid_w;
  logic [1:0]  clr_w;
  logic [1:0]  ready_w;
  logic [2:0]  op_w [2];
  logic [17:0] s1_w [2];
  logic [17:0] s2_w [2];

  assign valid_w = {bus.req_valid_1, bus.req_valid_0};
  assign clr_w   = {bus.flags_clr_1, bus.flags_clr_0};
  assign op_w[0] = bus.req_op_0;
  assign op_w[1] = bus.req_op_1;
  assign s1_w[0] = bus.req_s1_0;
  assign s1_w[1] = bus.req_s1_1;
  assign s2_w[0] = bus.req_s2_0;
  assign s2_w[1] = bus.req_s2_1;

  logic ptr_q, ptr_d;
  logic gnt_w, gnt_id_w;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    ready_w = 2'b00;
    if (rst_n) begin
      if (valid_w[0] && (!valid_w[1] || !ptr_q)) begin
        ready_w[0] = 1'b1;
      end else if (valid_w[1]) begin
        ready_w[1] = 1'b1;
      end
    end
  end

  assign gnt_w    = |ready_w;
  assign gnt_id_w = ready_w[1];
  assign ptr_d    = gnt_w ? ~gnt_id_w : ptr_q;

  assign bus.req_ready_0 = ready_w[0];
  assign bus.req_ready_1 = ready_w[1];

  logic        iss_valid_q, iss_valid_d;
  logic        iss_id_q, iss_id_d;
  logic [2:0]  iss_op_q, iss_op_d;
  logic [17:0] iss_s1_q, iss_s1_d;
  logic [17:0] iss_s2_q, iss_s2_d;

  always_comb begin
    iss_valid_d = gnt_w;
    iss_id_d    = iss_id_q;
    iss_op_d    = iss_op_q;
    iss_s1_d    = iss_s1_q;
    iss_s2_d    = iss_s2_q;
    if (gnt_w) begin
      iss_id_d = gnt_id_w;
      iss_op_d = op_w[gnt_id_w];
      iss_s1_d = s1_w[gnt_id_w];
      iss_s2_d = s2_w[gnt_id_w];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= PTR_RST;
      iss_valid_q <= 1'b0;
      iss_id_q    <= 1'b0;
      iss_op_q    <= '0;
      iss_s1_q    <= '0;
      iss_s2_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q    <= iss_id_d;
      iss_op_q    <= iss_op_d;
      iss_s1_q    <= iss_s1_d;
      iss_s2_q    <= iss_s2_d;
    end
  end

  logic [1:0][3:0]  flags_q;
  logic [1:0]       rsp_valid_q;
  logic [1:0][17:0] rsp_res_q;
  logic [1:0][3:0]  rsp_flags_q;

  // The ALU bus is idle-zero so an unissued cycle never looks like an op.
  always_comb begin
    bus.alu_op    = '0;
    bus.alu_s1    = '0;
    bus.alu_s2    = '0;
    bus.alu_flags = '0;
    if (iss_valid_q) begin
      bus.alu_op    = iss_op_q;
      bus.alu_s1    = iss_s1_q;
      bus.alu_s2    = iss_s2_q;
      bus.alu_flags = flags_q[iss_id_q];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic own_w;
    assign own_w = iss_valid_q && (iss_id_q == 1'(gi));

    // Writing the flags at the end of the issue cycle lets the very next op
    // from the same requester read them; a same-edge clear overrides the write.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        flags_q[gi]     <= '0;
        rsp_valid_q[gi] <= 1'b0;
        rsp_res_q[gi]   <= '0;
        rsp_flags_q[gi] <= '0;
      end else begin
        rsp_valid_q[gi] <= own_w;
        if (own_w) begin
          rsp_res_q[gi]   <= bus.alu_res;
          rsp_flags_q[gi] <= bus.alu_new_flags;
        end
        if (clr_w[gi]) begin
          flags_q[gi] <= '0;
        end else if (own_w) begin
          flags_q[gi] <= bus.alu_new_flags;
        end
      end
    end
  end

  assign bus.rsp_valid_0 = rsp_valid_q[0];
  assign bus.rsp_valid_1 = rsp_valid_q[1];
  assign bus.rsp_res_0   = rsp_res_q[0];
  assign bus.rsp_res_1   = rsp_res_q[1];
  assign bus.rsp_flags_0 = rsp_flags_q[0];
  assign bus.rsp_flags_1 = rsp_flags_q[1];
endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: provides the shared ALU, a transaction-level reference model,
// a table of directed single ops, hand-written pipeline corner cases and random traffic.
module tb_alu_arb;
  localparam logic [2:0] OP_AND = 3'd0, OP_XOR = 3'd2, OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5, OP_ADDC = 3'd6;
  localparam logic TB_RR = 1'b0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arb_if bus();
  alu_arb #(.RR_INIT(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Shared ALU: flags are {c,o,s,z}; subtraction carry means "no borrow".
  function automatic logic [21:0] alu_f(input logic [2:0] op, input logic [17:0] a,
                                        input logic [17:0] b, input logic [3:0] f);
    logic [18:0] w;
    logic [17:0] r;
    logic c, o;
    w = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = {b[8:0], 9'd0};
      3'd4: w = {1'b0, a} + {1'b0, b};
      3'd5: w = {1'b0, a} + {1'b0, ~b} + 19'd1;
      3'd6: w = {1'b0, a} + {1'b0, b} + {18'd0, f[3]};
      default: w = {1'b0, a} + {1'b0, ~b} + {18'd0, f[3]};
    endcase
    if (op[2]) begin
      r = w[17:0];
      c = w[18];
      if (op[0]) o = (a[17] != b[17]) && (r[17] != a[17]);
      else       o = (a[17] == b[17]) && (r[17] != a[17]);
    end
    return {c, o, r[17], (r == 18'd0), r};
  endfunction

  logic [21:0] alu_out;
  always_comb alu_out = alu_f(bus.alu_op, bus.alu_s1, bus.alu_s2, bus.alu_flags);
  assign bus.alu_res       = alu_out[17:0];
  assign bus.alu_new_flags = alu_out[21:18];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Reference model: who has priority, the op accepted last edge, per-requester state.
  logic        m_prio;
  logic        m_pv, m_pid;
  logic [2:0]  m_pop;
  logic [17:0] m_ps1, m_ps2;
  logic [3:0]  m_flags [2];
  logic [17:0] m_rres [2];
  logic [3:0]  m_rfl [2];
  logic [1:0]  obs_rdy;

  task automatic model_reset();
    m_prio = TB_RR;
    m_pv = 1'b0; m_pid = 1'b0; m_pop = '0; m_ps1 = '0; m_ps2 = '0;
    for (int i = 0; i < 2; i++) begin
      m_flags[i] = '0; m_rres[i] = '0; m_rfl[i] = '0;
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic cycle(input logic v0, input logic v1, input logic [2:0] o0, input logic [2:0] o1,
                       input logic [17:0] a0, input logic [17:0] b0,
                       input logic [17:0] a1, input logic [17:0] b1,
                       input logic c0, input logic c1);
    logic [1:0]  erdy, erv;
    logic [21:0] r;
    bus.req_valid_0 = v0; bus.req_valid_1 = v1;
    bus.req_op_0 = o0; bus.req_op_1 = o1;
    bus.req_s1_0 = a0; bus.req_s2_0 = b0;
    bus.req_s1_1 = a1; bus.req_s2_1 = b1;
    bus.flags_clr_0 = c0; bus.flags_clr_1 = c1;
    #1;
    erdy = 2'b00;
    if (rst_n) begin
      if (v0 && v1) erdy[m_prio] = 1'b1;
      else if (v0)  erdy[0] = 1'b1;
      else if (v1)  erdy[1] = 1'b1;
    end
    obs_rdy = {bus.req_ready_1, bus.req_ready_0};
    chk("ready", 32'(obs_rdy), 32'(erdy));
    chk("alu_op", 32'(bus.alu_op), m_pv ? 32'(m_pop) : 32'd0);
    chk("alu_s1", 32'(bus.alu_s1), m_pv ? 32'(m_ps1) : 32'd0);
    chk("alu_s2", 32'(bus.alu_s2), m_pv ? 32'(m_ps2) : 32'd0);
    chk("alu_flags", 32'(bus.alu_flags), m_pv ? 32'(m_flags[m_pid]) : 32'd0);
    @(posedge clk); #1;
    erv = 2'b00;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_pv) begin
        r = alu_f(m_pop, m_ps1, m_ps2, m_flags[m_pid]);
        m_rres[m_pid]  = r[17:0];
        m_rfl[m_pid]   = r[21:18];
        m_flags[m_pid] = r[21:18];
        erv[m_pid]     = 1'b1;
      end
      if (c0) m_flags[0] = '0;
      if (c1) m_flags[1] = '0;
      m_pv = |erdy;
      if (m_pv) begin
        m_pid  = erdy[1];
        m_pop  = erdy[1] ? o1 : o0;
        m_ps1  = erdy[1] ? a1 : a0;
        m_ps2  = erdy[1] ? b1 : b0;
        m_prio = ~erdy[1];
      end
    end
    chk("rsp_valid", 32'({bus.rsp_valid_1, bus.rsp_valid_0}), 32'(erv));
    chk("rsp_res_0", 32'(bus.rsp_res_0), 32'(m_rres[0]));
    chk("rsp_res_1", 32'(bus.rsp_res_1), 32'(m_rres[1]));
    chk("rsp_flags_0", 32'(bus.rsp_flags_0), 32'(m_rfl[0]));
    chk("rsp_flags_1", 32'(bus.rsp_flags_1), 32'(m_rfl[1]));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 3'd0, 3'd0, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic id, input logic [2:0] op, input logic [17:0] a,
                      input logic [17:0] b, input logic c0, input logic c1);
    if (id) cycle(1'b0, 1'b1, 3'd0, op, 18'd0, 18'd0, a, b, c0, c1);
    else    cycle(1'b1, 1'b0, op, 3'd0, a, b, 18'd0, 18'd0, c0, c1);
  endtask

  function automatic logic [17:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 18'd0;
      1: return 18'd1;
      2: return 18'h1FFFF;
      3: return 18'h20000;
      4: return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  typedef struct packed {
    logic        id;
    logic [2:0]  op;
    logic [17:0] s1;
    logic [17:0] s2;
    logic [17:0] res;
    logic [3:0]  fl;
  } vec_t;

  initial begin
    vec_t vtab [11];
    logic rv;
    logic [17:0] rres;
    logic [3:0]  rfl;
    vtab[0]  = '{1'b0, OP_ADD,  18'h3FFFF, 18'h00001, 18'h00000, 4'b1001};
    vtab[1]  = '{1'b0, OP_ADDC, 18'h00000, 18'h00000, 18'h00001, 4'b0000};
    vtab[2]  = '{1'b0, OP_SUB,  18'h00005, 18'h00005, 18'h00000, 4'b1001};
    vtab[3]  = '{1'b0, OP_SUB,  18'h00000, 18'h00001, 18'h3FFFF, 4'b0010};
    vtab[4]  = '{1'b0, OP_ADD,  18'h1FFFF, 18'h00001, 18'h20000, 4'b0110};
    vtab[5]  = '{1'b0, OP_ADD,  18'h3FFFF, 18'h00001, 18'h00000, 4'b1001};
    vtab[6]  = '{1'b1, OP_ADD,  18'h00001, 18'h00001, 18'h00002, 4'b0000};
    vtab[7]  = '{1'b0, OP_ADDC, 18'h00000, 18'h00000, 18'h00001, 4'b0000};
    vtab[8]  = '{1'b1, OP_AND,  18'h00003, 18'h00005, 18'h00001, 4'b0000};
    vtab[9]  = '{1'b1, OP_XOR,  18'h00003, 18'h00003, 18'h00000, 4'b0001};
    vtab[10] = '{1'b1, OP_ADDC, 18'h00000, 18'h00000, 18'h00000, 4'b0001};

    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_op_0 = '0; bus.req_op_1 = '0;
    bus.req_s1_0 = '0; bus.req_s2_0 = '0; bus.req_s1_1 = '0; bus.req_s2_1 = '0;
    bus.flags_clr_0 = 1'b0; bus.flags_clr_1 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle();
    chk("reset_rsp_valid", 32'({bus.rsp_valid_1, bus.rsp_valid_0}), 32'd0);
    chk("reset_rsp_res_0", 32'(bus.rsp_res_0), 32'd0);
    rst_n = 1'b1;

    // Directed single ops, each allowed to complete before the next.
    for (int i = 0; i < 11; i++) begin
      send(vtab[i].id, vtab[i].op, vtab[i].s1, vtab[i].s2, 1'b0, 1'b0);
      idle();
      rv   = vtab[i].id ? bus.rsp_valid_1 : bus.rsp_valid_0;
      rres = vtab[i].id ? bus.rsp_res_1   : bus.rsp_res_0;
      rfl  = vtab[i].id ? bus.rsp_flags_1 : bus.rsp_flags_0;
      chk($sformatf("vec%0d_valid", i), 32'(rv), 32'd1);
      chk($sformatf("vec%0d_res", i), 32'(rres), 32'(vtab[i].res));
      chk($sformatf("vec%0d_flags", i), 32'(rfl), 32'(vtab[i].fl));
    end

    // Back-to-back carry chain from requester 0.
    rst_n = 1'b0; idle(); rst_n = 1'b1;
    send(1'b0, OP_ADD, 18'h3FFFF, 18'h00001, 1'b0, 1'b0);
    send(1'b0, OP_ADDC, 18'h0, 18'h0, 1'b0, 1'b0);
    chk("b2b_add_valid", 32'(bus.rsp_valid_0), 32'd1);
    chk("b2b_add_flags", 32'(bus.rsp_flags_0), 32'b1001);
    idle();
    chk("b2b_addc_valid", 32'(bus.rsp_valid_0), 32'd1);
    chk("b2b_addc_res", 32'(bus.rsp_res_0), 32'h1);
    chk("b2b_addc_flags", 32'(bus.rsp_flags_0), 32'b0000);
    idle();
    chk("b2b_strobe_drop", 32'(bus.rsp_valid_0), 32'd0);
    chk("b2b_res_hold", 32'(bus.rsp_res_0), 32'h1);

    // Clear on the same edge as a carry-producing issue wins.
    send(1'b0, OP_ADD, 18'h3FFFF, 18'h00001, 1'b0, 1'b0);
    send(1'b0, OP_ADDC, 18'h0, 18'h0, 1'b1, 1'b0);
    idle();
    chk("clr_addc_valid", 32'(bus.rsp_valid_0), 32'd1);
    chk("clr_addc_res", 32'(bus.rsp_res_0), 32'h0);
    idle();

    // Both requesters valid continuously from reset.
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, OP_ADD, OP_ADD, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0);
    chk("rr_reset_ready", 32'(obs_rdy), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, OP_ADD, OP_ADD, 18'(k), 18'd0, 18'(k + 100), 18'd0, 1'b0, 1'b0);
      chk($sformatf("rr_grant%0d", k), 32'(obs_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0)
        chk($sformatf("rr_rsp%0d", k), 32'({bus.rsp_valid_1, bus.rsp_valid_0}),
            ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle(); idle();

    // Reset while an op is in the issue register.
    send(1'b0, OP_ADD, 18'h3FFFF, 18'h00001, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, OP_ADD, OP_ADD, 18'h3FFFF, 18'h1, 18'h3FFFF, 18'h1, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("rst_inflight_drop", 32'({bus.rsp_valid_1, bus.rsp_valid_0}), 32'd0);
    cycle(1'b1, 1'b1, OP_ADDC, OP_ADDC, 18'd0, 18'd0, 18'd0, 18'd0, 1'b0, 1'b0);
    chk("rst_ptr_init", 32'(obs_rdy), 32'd1);
    idle();
    chk("rst_flags_res", 32'(bus.rsp_res_0), 32'h0);
    chk("rst_flags_fl", 32'(bus.rsp_flags_0), 32'b0001);
    idle();

    // Random traffic with occasional clears and resets.
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            rnd_opnd(), rnd_opnd(), rnd_opnd(), rnd_opnd(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b1;
    idle(); idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
